// File: rtl/ball_phys_pkg.sv
// Shared constants, resolver state type and speed clamp for the ball physics blocks.
package ball_phys_pkg;

    localparam int FIXED_POINT_MULTIPLIER = 64;
    localparam int MAX_SPEED              = 230;

    typedef enum logic [2:0] {
        IDLE,
        CALC,
        DIV_X,
        DIV_Y,
        APPLY
    } resolver_state_e;

    function automatic logic signed [31:0] clamp_speed(input logic signed [31:0] v,
                                                       input int                 limit);
        logic signed [31:0] lim;
        lim = 32'(limit);
        if (v > lim)
            return lim;
        else if (v < -lim)
            return -lim;
        else
            return v;
    endfunction

endpackage

// File: rtl/serial_signed_divider.sv
// Restoring signed divider, one quotient bit per clock; truncates toward zero.
module serial_signed_divider #(
    parameter int WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    resetN,
    input  logic                    start,
    input  logic signed [WIDTH-1:0] numer,
    input  logic signed [WIDTH-1:0] denom,
    output logic                    done,
    output logic signed [WIDTH-1:0] quotient
);
    localparam int CW = $clog2(WIDTH) + 1;

    logic             running_q, running_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] den_q, den_d;
    logic             neg_q, neg_d;
    logic             zero_q, zero_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] quot_q, quot_d;

    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   diff;
    logic             fits;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] acc_next;

    always_comb begin
        // acc holds the unconsumed numerator bits and collects quotient bits from the right
        trial    = {rem_q, acc_q[WIDTH-1]};
        diff     = trial - {1'b0, den_q};
        fits     = trial >= {1'b0, den_q};
        rem_next = fits ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
        acc_next = {acc_q[WIDTH-2:0], fits};

        running_d = running_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        rem_d     = rem_q;
        den_d     = den_q;
        neg_d     = neg_q;
        zero_d    = zero_q;
        done_d    = 1'b0;
        quot_d    = quot_q;

        if (start) begin
            acc_d     = numer[WIDTH-1] ? WIDTH'(-numer) : numer;
            den_d     = denom[WIDTH-1] ? WIDTH'(-denom) : denom;
            rem_d     = '0;
            neg_d     = numer[WIDTH-1] ^ denom[WIDTH-1];
            zero_d    = (denom == '0);
            cnt_d     = '0;
            running_d = 1'b1;
        end else if (running_q) begin
            rem_d = rem_next;
            acc_d = acc_next;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(WIDTH - 1)) begin
                running_d = 1'b0;
                done_d    = 1'b1;
                quot_d    = zero_q ? '0 : (neg_q ? WIDTH'(-acc_next) : acc_next);
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            running_q <= 1'b0;
            cnt_q     <= '0;
            acc_q     <= '0;
            rem_q     <= '0;
            den_q     <= '0;
            neg_q     <= 1'b0;
            zero_q    <= 1'b0;
            done_q    <= 1'b0;
            quot_q    <= '0;
        end else begin
            running_q <= running_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            rem_q     <= rem_d;
            den_q     <= den_d;
            neg_q     <= neg_d;
            zero_q    <= zero_d;
            done_q    <= done_d;
            quot_q    <= quot_d;
        end
    end

    assign done     = done_q;
    assign quotient = quot_q;

endmodule

// File: rtl/ball_pair_collision_resolver.sv
// Elastic equal-mass two-ball collision: latches a snapshot on the detector edge and
// produces clamped post-impact speeds for both balls' move logic.
module ball_pair_collision_resolver
    import ball_phys_pkg::*;
#(
    parameter int MAX_SPEED = ball_phys_pkg::MAX_SPEED,
    parameter int DIV_WIDTH = 32
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               startOfFrame,
    input  logic               collisionTwoBalls,
    input  logic signed [10:0] posAX,
    input  logic signed [10:0] posAY,
    input  logic signed [10:0] posBX,
    input  logic signed [10:0] posBY,
    input  logic signed [31:0] xSpeedA,
    input  logic signed [31:0] ySpeedA,
    input  logic signed [31:0] xSpeedB,
    input  logic signed [31:0] ySpeedB,
    output logic signed [31:0] xSpeedNewA,
    output logic signed [31:0] ySpeedNewA,
    output logic signed [31:0] xSpeedNewB,
    output logic signed [31:0] ySpeedNewB,
    output logic               newValid,
    output logic               busy
);
    resolver_state_e state_q, state_d;

    logic               coll_prev_q, coll_prev_d;
    logic               frame_lock_q, frame_lock_d;
    logic signed [10:0] pax_q, pax_d, pay_q, pay_d, pbx_q, pbx_d, pby_q, pby_d;
    logic signed [31:0] vxa_q, vxa_d, vya_q, vya_d, vxb_q, vxb_d, vyb_q, vyb_d;
    logic signed [31:0] qx_q, qx_d, qy_q, qy_d;
    logic signed [31:0] xa_q, xa_d, ya_q, ya_d, xb_q, xb_d, yb_q, yb_d;
    logic               new_valid_q, new_valid_d;

    logic               trigger;
    logic signed [31:0] dx, dy, dvx, dvy, dot, d2;
    logic               div_start, div_done;
    logic signed [DIV_WIDTH-1:0] div_numer, div_denom, div_quot;

    // The latched snapshot is frozen until the next trigger, so the geometry can stay combinational.
    always_comb begin
        dx  = 32'(pbx_q) - 32'(pax_q);
        dy  = 32'(pby_q) - 32'(pay_q);
        dvx = vxa_q - vxb_q;
        dvy = vya_q - vyb_q;
        dot = dvx * dx + dvy * dy;
        d2  = dx * dx + dy * dy;
    end

    assign div_numer = (state_q == CALC) ? dot * dx : dot * dy;
    assign div_denom = d2;

    always_comb begin
        state_d      = state_q;
        coll_prev_d  = collisionTwoBalls;
        frame_lock_d = startOfFrame ? 1'b0 : frame_lock_q;
        pax_d = pax_q;  pay_d = pay_q;  pbx_d = pbx_q;  pby_d = pby_q;
        vxa_d = vxa_q;  vya_d = vya_q;  vxb_d = vxb_q;  vyb_d = vyb_q;
        qx_d  = qx_q;   qy_d  = qy_q;
        xa_d  = xa_q;   ya_d  = ya_q;   xb_d  = xb_q;   yb_d  = yb_q;
        new_valid_d = 1'b0;
        div_start   = 1'b0;

        trigger = (state_q == IDLE) && !frame_lock_q && collisionTwoBalls && !coll_prev_q;

        case (state_q)
            IDLE: begin
                if (trigger) begin
                    frame_lock_d = 1'b1;
                    pax_d = posAX;    pay_d = posAY;    pbx_d = posBX;    pby_d = posBY;
                    vxa_d = xSpeedA;  vya_d = ySpeedA;  vxb_d = xSpeedB;  vyb_d = ySpeedB;
                    state_d = CALC;
                end
            end
            CALC: begin
                if (dot <= 0 || d2 == 0) begin
                    qx_d    = '0;
                    qy_d    = '0;
                    state_d = APPLY;
                end else begin
                    div_start = 1'b1;
                    state_d   = DIV_X;
                end
            end
            DIV_X: begin
                if (div_done) begin
                    qx_d      = div_quot;
                    div_start = 1'b1;
                    state_d   = DIV_Y;
                end
            end
            DIV_Y: begin
                if (div_done) begin
                    qy_d    = div_quot;
                    state_d = APPLY;
                end
            end
            APPLY: begin
                xa_d = clamp_speed(vxa_q - qx_q, MAX_SPEED);
                ya_d = clamp_speed(vya_q - qy_q, MAX_SPEED);
                xb_d = clamp_speed(vxb_q + qx_q, MAX_SPEED);
                yb_d = clamp_speed(vyb_q + qy_q, MAX_SPEED);
                new_valid_d = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q      <= IDLE;
            coll_prev_q  <= 1'b0;
            frame_lock_q <= 1'b0;
            pax_q <= '0;  pay_q <= '0;  pbx_q <= '0;  pby_q <= '0;
            vxa_q <= '0;  vya_q <= '0;  vxb_q <= '0;  vyb_q <= '0;
            qx_q  <= '0;  qy_q  <= '0;
            xa_q  <= '0;  ya_q  <= '0;  xb_q  <= '0;  yb_q  <= '0;
            new_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            coll_prev_q  <= coll_prev_d;
            frame_lock_q <= frame_lock_d;
            pax_q <= pax_d;  pay_q <= pay_d;  pbx_q <= pbx_d;  pby_q <= pby_d;
            vxa_q <= vxa_d;  vya_q <= vya_d;  vxb_q <= vxb_d;  vyb_q <= vyb_d;
            qx_q  <= qx_d;   qy_q  <= qy_d;
            xa_q  <= xa_d;   ya_q  <= ya_d;   xb_q  <= xb_d;   yb_q  <= yb_d;
            new_valid_q <= new_valid_d;
        end
    end

    serial_signed_divider #(
        .WIDTH(DIV_WIDTH)
    ) u_div (
        .clk     (clk),
        .resetN  (resetN),
        .start   (div_start),
        .numer   (div_numer),
        .denom   (div_denom),
        .done    (div_done),
        .quotient(div_quot)
    );

    assign xSpeedNewA = xa_q;
    assign ySpeedNewA = ya_q;
    assign xSpeedNewB = xb_q;
    assign ySpeedNewB = yb_q;
    assign newValid   = new_valid_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_ball_pair_collision_resolver.sv
// Scoreboard bench: stimulus pushes reference-model results, a monitor checks each newValid.
module tb_ball_pair_collision_resolver;

    logic               clk = 1'b0;
    logic               resetN;
    logic               startOfFrame;
    logic               collisionTwoBalls;
    logic signed [10:0] posAX, posAY, posBX, posBY;
    logic signed [31:0] xSpeedA, ySpeedA, xSpeedB, ySpeedB;
    logic signed [31:0] xSpeedNewA, ySpeedNewA, xSpeedNewB, ySpeedNewB;
    logic               newValid;
    logic               busy;

    typedef struct {
        int xa;
        int ya;
        int xb;
        int yb;
        int lat;
        int trig;
    } exp_t;

    exp_t exp_q[$];
    exp_t last_e;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    bit   lock_m = 1'b0;

    ball_pair_collision_resolver #(
        .MAX_SPEED(230),
        .DIV_WIDTH(32)
    ) dut (
        .clk              (clk),
        .resetN           (resetN),
        .startOfFrame     (startOfFrame),
        .collisionTwoBalls(collisionTwoBalls),
        .posAX            (posAX),
        .posAY            (posAY),
        .posBX            (posBX),
        .posBY            (posBY),
        .xSpeedA          (xSpeedA),
        .ySpeedA          (ySpeedA),
        .xSpeedB          (xSpeedB),
        .ySpeedB          (ySpeedB),
        .xSpeedNewA       (xSpeedNewA),
        .ySpeedNewA       (ySpeedNewA),
        .xSpeedNewB       (xSpeedNewB),
        .ySpeedNewB       (ySpeedNewB),
        .newValid         (newValid),
        .busy             (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic int clampm(input int v);
        if (v > 230) return 230;
        if (v < -230) return -230;
        return v;
    endfunction

    // Elastic equal-mass exchange along the line of centres, straight from the physics rules.
    function automatic exp_t model(input int ax, ay, bx, by, vxa, vya, vxb, vyb);
        exp_t e;
        int dx, dy, dot, d2, qx, qy;
        dx  = bx - ax;
        dy  = by - ay;
        dot = (vxa - vxb) * dx + (vya - vyb) * dy;
        d2  = dx * dx + dy * dy;
        if (dot <= 0 || d2 == 0) begin
            qx = 0; qy = 0; e.lat = 3;
        end else begin
            qx = (dot * dx) / d2;
            qy = (dot * dy) / d2;
            e.lat = 69;
        end
        e.xa = clampm(vxa - qx);
        e.ya = clampm(vya - qy);
        e.xb = clampm(vxb + qx);
        e.yb = clampm(vyb + qy);
        e.trig = 0;
        return e;
    endfunction

    // Latency counts edges from the trigger-sampling edge to the edge that captures newValid high.
    always @(negedge clk) begin
        if (newValid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_newValid actual=1 required=0 (t=%0t)", $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("xSpeedNewA", xSpeedNewA, e.xa);
                chk("ySpeedNewA", ySpeedNewA, e.ya);
                chk("xSpeedNewB", xSpeedNewB, e.xb);
                chk("ySpeedNewB", ySpeedNewB, e.yb);
                chk("latency", cyc + 1 - e.trig, e.lat);
                last_e = e;
            end
        end
    end

    task automatic sof_pulse();
        @(negedge clk);
        startOfFrame = 1'b1;
        @(negedge clk);
        startOfFrame = 1'b0;
        lock_m = 1'b0;
    endtask

    task automatic issue(input int ax, ay, bx, by, vxa, vya, vxb, vyb, input bit sof_same);
        exp_t e;
        @(negedge clk);
        collisionTwoBalls = 1'b0;
        posAX = 11'(ax);  posAY = 11'(ay);  posBX = 11'(bx);  posBY = 11'(by);
        xSpeedA = vxa;    ySpeedA = vya;    xSpeedB = vxb;    ySpeedB = vyb;
        @(negedge clk);
        collisionTwoBalls = 1'b1;
        startOfFrame = sof_same;
        if (!lock_m) begin
            e = model(ax, ay, bx, by, vxa, vya, vxb, vyb);
            e.trig = cyc + 1;
            exp_q.push_back(e);
            lock_m = 1'b1;
        end else if (sof_same) begin
            lock_m = 1'b0;
        end
        @(negedge clk);
        startOfFrame = 1'b0;
        posAX = 11'($urandom_range(0, 500));
        posBX = 11'($urandom_range(0, 500));
        xSpeedA = int'($urandom_range(0, 600)) - 300;
        ySpeedB = int'($urandom_range(0, 600)) - 300;
    endtask

    task automatic wait_result();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL wait_result actual=timeout required=newValid (t=%0t)", $time);
            exp_q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic run_case(input int ax, ay, bx, by, vxa, vya, vxb, vyb);
        sof_pulse();
        issue(ax, ay, bx, by, vxa, vya, vxb, vyb, 1'b0);
        wait_result();
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        resetN = 1'b0;
        startOfFrame = 1'b0;
        collisionTwoBalls = 1'b0;
        posAX = '0; posAY = '0; posBX = '0; posBY = '0;
        xSpeedA = '0; ySpeedA = '0; xSpeedB = '0; ySpeedB = '0;
        repeat (3) @(negedge clk);
        chk("reset_xA", xSpeedNewA, 0);
        chk("reset_yB", ySpeedNewB, 0);
        chk("reset_newValid", newValid, 0);
        chk("reset_busy", busy, 0);
        resetN = 1'b1;
        repeat (2) @(negedge clk);

        run_case(100, 100, 132, 100, 64, 0, 0, 0);          // head-on
        run_case(100, 100, 132, 132, 64, 0, 0, 0);          // 45 degree glancing
        run_case(100, 100, 132, 100, -64, 0, 0, 0);         // separating
        run_case(150, 150, 150, 150, 40, -20, -40, 20);     // coincident, d2 = 0
        run_case(100, 100, 132, 100, 230, 0, -230, 0);      // max opposing
        run_case(100, 100, 132, 100, 300, 0, -230, 0);      // pre-clamp overflow

        // second edge in the same frame is ignored; busy stays low and outputs hold
        issue(100, 100, 132, 100, 64, 0, 0, 0, 1'b0);
        repeat (3) @(negedge clk);
        chk("ignored_busy", busy, 0);
        repeat (80) @(negedge clk);
        chk("held_xSpeedNewB", xSpeedNewB, last_e.xb);
        wait_result();

        // startOfFrame coinciding with a trigger: accepted, and the frame stays locked
        sof_pulse();
        issue(100, 100, 132, 132, 64, 0, 0, 0, 1'b1);
        wait_result();
        issue(100, 100, 132, 100, 64, 0, 0, 0, 1'b0);
        repeat (80) @(negedge clk);
        run_case(100, 100, 132, 100, 64, 0, 0, 0);

        // reset in the middle of the first division
        sof_pulse();
        issue(100, 100, 132, 100, 64, 0, 0, 0, 1'b0);
        repeat (10) @(negedge clk);
        chk("busy_in_div", busy, 1);
        resetN = 1'b0;
        collisionTwoBalls = 1'b0;
        exp_q.delete();
        lock_m = 1'b0;
        #1;
        chk("midreset_xB", xSpeedNewB, 0);
        chk("midreset_yA", ySpeedNewA, 0);
        chk("midreset_busy", busy, 0);
        @(negedge clk);
        resetN = 1'b1;
        repeat (80) @(negedge clk);
        issue(100, 100, 132, 132, 64, 0, 0, 0, 1'b0);
        wait_result();

        for (int i = 0; i < 20; i++) begin
            int ax, ay;
            ax = int'($urandom_range(100, 300));
            ay = int'($urandom_range(100, 300));
            run_case(ax, ay,
                     ax + int'($urandom_range(0, 80)) - 40,
                     ay + int'($urandom_range(0, 80)) - 40,
                     int'($urandom_range(0, 600)) - 300,
                     int'($urandom_range(0, 600)) - 300,
                     int'($urandom_range(0, 600)) - 300,
                     int'($urandom_range(0, 600)) - 300);
        end

        repeat (5) @(negedge clk);
        chk("pending_results", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
